// File: rtl/internal_bus_arbiter_pkg.sv
// rtl/internal_bus_arbiter_pkg.sv - shared encodings and helpers for the internal bus arbiter
package internal_bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_e;

  // Never returns less than 1 so a 1-bit index still exists for tiny N.
  function automatic int clog2(input int value);
    int w = 1;
    while ((1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/internal_bus_arbiter_rr_pick.sv
// rtl/internal_bus_arbiter_rr_pick.sv - combinational round-robin picker: first requester at or after ptr
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  pick_o,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    int j;
    j       = 0;
    pick_o  = '0;
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!valid_o && req_i[j]) begin
        valid_o   = 1'b1;
        pick_o[j] = 1'b1;
        idx_o     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/internal_bus_arbiter.sv
// rtl/internal_bus_arbiter.sv - registered N-master round-robin arbiter onto the external read/write bus
// Grant, strobes and completion strobes are all registered; one transaction in flight at a time.
module internal_bus_arbiter
  import internal_bus_arb_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255,
  parameter int CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS-1:0]        req_rd,
  input  logic [N_MASTERS-1:0]        req_wr,
  input  logic [N_MASTERS*ADDR_W-1:0] req_addr,
  input  logic [N_MASTERS*DATA_W-1:0] req_data,
  output logic [N_MASTERS-1:0]        gnt,
  output logic [N_MASTERS-1:0]        done,
  output logic [N_MASTERS-1:0]        err,
  output logic [DATA_W-1:0]           rdata,
  input  logic                        bus_busy,
  output logic                        read_q,
  output logic                        write_q,
  output logic [ADDR_W-1:0]           addr_out,
  output logic [DATA_W-1:0]           data_out,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        read_dn,
  input  logic                        write_dn
);

  localparam int IW = clog2(N_MASTERS);

  arb_state_e           state_q;
  arb_op_e              op_q;
  logic [IW-1:0]        ptr_q, idx_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [ADDR_W-1:0]    addr_lat_q, addr_out_q;
  logic [DATA_W-1:0]    data_lat_q, data_out_q, rdata_q;
  logic [N_MASTERS-1:0] gnt_q, done_q, err_q;
  logic                 rd_stb_q, wr_stb_q;

  logic [N_MASTERS-1:0] pick_oh;
  logic                 pick_valid;
  logic [IW-1:0]        pick_idx;

  rr_pick #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_rr_pick (
    .req_i   (req_rd | req_wr),
    .ptr_i   (ptr_q),
    .pick_o  (pick_oh),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [CNT_W-1:0]  cnt_d;
  logic [IW-1:0]     ptr_d;
  logic              dn_hit, timeout_hit;

  assign sel_addr    = req_addr[int'(pick_idx) * ADDR_W +: ADDR_W];
  assign sel_data    = req_data[int'(pick_idx) * DATA_W +: DATA_W];
  assign dn_hit      = (op_q == OP_WR) ? write_dn : read_dn;
  assign cnt_d       = cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT));
  assign ptr_d       = (idx_q == IW'(N_MASTERS - 1)) ? '0 : idx_q + IW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_RD;
      ptr_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      addr_lat_q <= '0;
      data_lat_q <= '0;
      addr_out_q <= '0;
      data_out_q <= '0;
      rdata_q    <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      rd_stb_q   <= 1'b0;
      wr_stb_q   <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_q      <= pick_oh;
            idx_q      <= pick_idx;
            addr_lat_q <= sel_addr;
            data_lat_q <= sel_data;
            op_q       <= req_wr[pick_idx] ? OP_WR : OP_RD;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!bus_busy) begin
            rd_stb_q   <= (op_q == OP_RD);
            wr_stb_q   <= (op_q == OP_WR);
            addr_out_q <= addr_lat_q;
            data_out_q <= (op_q == OP_WR) ? data_lat_q : '0;
            cnt_q      <= '0;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A dn on the timeout edge wins, so it is tested first.
          if (dn_hit || timeout_hit) begin
            rd_stb_q   <= 1'b0;
            wr_stb_q   <= 1'b0;
            addr_out_q <= '0;
            data_out_q <= '0;
            gnt_q      <= '0;
            ptr_q      <= ptr_d;
            state_q    <= ST_IDLE;
            if (dn_hit) begin
              done_q <= gnt_q;
              if (op_q == OP_RD) rdata_q <= data_in;
            end else begin
              err_q <= gnt_q;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign read_q   = rd_stb_q;
  assign write_q  = wr_stb_q;
  assign addr_out = addr_out_q;
  assign data_out = data_out_q;

endmodule
